// File: rtl/fft_frame_scheduler.sv
// Feeds whole N-sample frames from NUM_ANT antenna buffers into a serial FFT engine,
// round-robin between ready buffers, and tags each FFT result with its source antenna.
module fft_frame_scheduler #(
    parameter int N            = 64,
    parameter int NUM_ANT      = 4,
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sched_en,
    input  logic [NUM_ANT-1:0]         ant_frame_rdy,
    input  logic [NUM_ANT*DATA_W-1:0]  ant_data,
    output logic [NUM_ANT-1:0]         ant_rd,
    output logic                       fft_enable,
    output logic [DATA_W-1:0]          fft_data_in,
    input  logic                       fft_out_valid,
    output logic [$clog2(NUM_ANT)-1:0] out_ant_id,
    output logic                       out_tag_valid,
    output logic                       busy,
    output logic                       sched_err
);

    localparam int AW = $clog2(NUM_ANT);
    localparam int CW = $clog2(N);
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int OW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     last_grant_q, last_grant_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     tag_mem_q [MAX_INFLIGHT];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]     occ_q;
    logic              fov_prev_q;
    logic              fft_enable_q;
    logic [DATA_W-1:0] fft_data_q;
    logic [AW-1:0]     out_ant_id_q;
    logic              out_tag_valid_q;
    logic              sched_err_q;

    logic              rr_found;
    logic [AW-1:0]     rr_idx;
    logic              fifo_full, fifo_empty, fov_rise, start, pop;
    logic [DATA_W-1:0] grant_sample;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin: first ready buffer at or after last_grant+1, wrapping around.
    always_comb begin : rr_search
        int          cand;
        logic [AW-1:0] cand_idx;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_ANT; i++) begin
            cand = int'(last_grant_q) + i;
            if (cand >= NUM_ANT) cand = cand - NUM_ANT;
            cand_idx = AW'(cand);
            if (!rr_found && ant_frame_rdy[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    assign fifo_full    = (occ_q == OW'(MAX_INFLIGHT));
    assign fifo_empty   = (occ_q == '0);
    assign fov_rise     = fft_out_valid && !fov_prev_q;
    assign pop          = fov_rise && !fifo_empty;
    assign start        = (state_q == IDLE) && sched_en && rr_found && !fifo_full;
    assign grant_sample = ant_data[int'(last_grant_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = STREAM;
                    last_grant_d = rr_idx;
                    cnt_d        = '0;
                end
            end
            STREAM: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pop strobes come straight from the state so reset kills them without a clock.
    for (genvar gi = 0; gi < NUM_ANT; gi++) begin : g_rd
        assign ant_rd[gi] = (state_q == STREAM) && (last_grant_q == AW'(gi));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            last_grant_q    <= AW'(NUM_ANT - 1);
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            fov_prev_q      <= 1'b0;
            fft_enable_q    <= 1'b0;
            fft_data_q      <= '0;
            out_ant_id_q    <= '0;
            out_tag_valid_q <= 1'b0;
            sched_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            fov_prev_q   <= fft_out_valid;
            fft_enable_q <= (state_q == STREAM);
            if (state_q == STREAM) fft_data_q <= grant_sample;
            if (start) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({start, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            out_tag_valid_q <= pop;
            if (pop) out_ant_id_q <= tag_mem_q[rd_ptr_q];
            if ((state_q == STREAM && !ant_frame_rdy[last_grant_q]) || (fov_rise && fifo_empty))
                sched_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) tag_mem_q[wr_ptr_q] <= rr_idx;
    end

    assign fft_enable    = fft_enable_q;
    assign fft_data_in   = fft_data_q;
    assign out_ant_id    = out_ant_id_q;
    assign out_tag_valid = out_tag_valid_q;
    assign busy          = (state_q != IDLE) || !fifo_empty;
    assign sched_err     = sched_err_q;

endmodule
